prog_loader: RTL
================

Name: prog_loader

Overview:
- Front-end stage directly upstream of the CPU core.
- Accepts a program as a byte stream over a valid/ready handshake and writes it sequentially into the core's 8-bit-address RAM.
- Holds the core in its await stage while loading, then issues a single-cycle run pulse to the stage sequencer.
- Owns the RAM write port only while loading. The core owns the RAM whenever cpu_hold is low.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, byte/word width.
- START_ADDR, 0, first RAM address written. Also where pc begins after run.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. Asynchronous, active-low.
- start  input  1  begin a load. Sampled in IDLE or DONE only.
- len  input  ADDR_W  byte count, latched on accepted start. 0 means 2^ADDR_W (256).
- in_valid  input  1  in_data holds a byte.
- in_data  input  DATA_W  program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- ram_addr  output  ADDR_W  write address to the RAM mux.
- ram_data  output  DATA_W  write data to the RAM mux.
- ram_wren  output  1  write strobe, one cycle per byte.
- cpu_hold  output  1  high means the core stays in await and the RAM mux selects the loader.
- run_pulse  output  1  one-cycle run to the stage sequencer.
- busy  output  1  load in progress.
- done  output  1  load finished. Held until the next start.
- err  output  1  checksum failure. Constant 0 without CHECKSUM_EN.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Counters and registers clear to 0.
  - All outputs are 0, except ram_addr = START_ADDR.
  - Reset mid-load aborts immediately. Bytes already written stay in RAM. No run_pulse is issued.
- States: IDLE, RECV, WRITE, RUN, DONE (plus CSUM with the option enabled).
- IDLE:
  - All outputs low.
  - On start=1: latch len into remaining, set addr = START_ADDR, go to RECV.
- RECV:
  - in_ready=1, busy=1, cpu_hold=1.
  - On in_valid=1: capture in_data and go to WRITE.
  - If in_valid=0: stay in RECV.
- WRITE:
  - ram_wren=1 for exactly one cycle, with ram_addr/ram_data equal to the captured byte's address and data. in_ready=0.
  - addr then increments modulo 2^ADDR_W, so it wraps 255 to 0. remaining decrements.
  - If remaining was 1, go to RUN; otherwise go back to RECV.
- Throughput: 1 byte per 2 cycles. Latency from accepted byte to ram_wren is 1 cycle.
- RUN:
  - run_pulse=1 and cpu_hold=0 for one cycle. busy=1.
  - Next state is DONE.
- DONE:
  - done=1. All other outputs low.
  - On start=1: clear done and go to RECV, same as from IDLE.
- start in RECV, WRITE or RUN is ignored.
- in_valid outside RECV is not acknowledged. The source must hold the byte until in_ready.
- len=0 loads 256 bytes, covering every address once with wrap.
- cpu_hold is high from the cycle after an accepted start through the last WRITE cycle.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CSUM with in_ready=1 and accepts one extra byte. That byte is not written to RAM.
  - If the sum of all data bytes plus the checksum, modulo 256, is 0: go to RUN.
  - Otherwise: set err=1, go to DONE with done=1 and no run_pulse. err clears on the next accepted start.
- Not defined: no CSUM state, no extra byte, err tied 0.

Test Plan:
- Reset mid-load: rst low during the 2nd WRITE -> all outputs 0 within the same cycle. After release, state is IDLE and no run_pulse ever appears.
- Basic load: start with len=3, then bytes 0x50,0x13,0xA0 with in_valid held high -> ram_wren pulses at addr 0,1,2 with those data, 2 cycles apart. One run_pulse follows the last write. done=1 afterwards.
- Backpressure: in_valid toggled 1,0,0,1 -> only 2 bytes accepted. No ram_wren while in_valid=0. Addresses stay contiguous.
- Wrap: START_ADDR=254, len=4 -> writes land at 254,255,0,1. len=0 -> exactly 256 ram_wren pulses, then run_pulse.
- Start ignored: start asserted during RECV with len=9 -> original len=2 is still honoured. Exactly 2 writes.
- With PROG_LOADER_CHECKSUM_EN: bytes 0x01,0x02 then checksum 0xFD -> run_pulse, err=0. Checksum 0xFC -> err=1, done=1, no run_pulse, and only 2 ram_wren pulses.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that fills core RAM and releases the core with a run pulse
// Optional checksum byte after the program: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              cpu_hold,
    output logic              run_pulse,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RUN,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] data_q;
    logic              last_byte;

    // remaining == 0 after latching len means a full 2^ADDR_W bytes; it wraps down to 1 at the end
    assign last_byte = (remaining == ADDR_W'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] csum_total;
    logic              err_q;

    assign csum_total = sum_q + in_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            addr      <= START_ADDR;
            remaining <= '0;
            data_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        remaining <= len;
                        addr      <= START_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_q     <= '0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                S_RECV: begin
                    if (in_valid) begin
                        data_q <= in_data;
                    end
                end
                S_WRITE: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_q     <= sum_q + data_q;
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (in_valid && (csum_total != '0)) begin
                        err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        ram_wren  = 1'b0;
        cpu_hold  = 1'b0;
        run_pulse = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RECV;
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_wren = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_n = S_CSUM;
`else
                    state_n = S_RUN;
`endif
                end else begin
                    state_n = S_RECV;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    state_n = (csum_total == '0) ? S_RUN : S_DONE;
                end
            end
`endif
            S_RUN: begin
                run_pulse = 1'b1;
                busy      = 1'b1;
                state_n   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_n = S_RECV;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign ram_addr = addr;
    assign ram_data = ram_wren ? data_q : '0;

`ifdef PROG_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
